// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: serves IC/DC line refills over one burst read port; define ARB_ROUND_ROBIN_EN for round-robin arbitration
module cache_refill_arbiter #(
  parameter int LINE_WIDTH  = 512,
  parameter int BEAT_WIDTH  = 32,
  parameter int BEATS       = LINE_WIDTH / BEAT_WIDTH,
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req,
  input  logic [31:0]            ic_addr,
  input  logic                   dc_req,
  input  logic [31:0]            dc_addr,
  output logic                   ic_grant,
  output logic                   dc_grant,
  output logic                   ic_fill_valid,
  output logic                   dc_fill_valid,
  output logic [LINE_WIDTH-1:0]  fill_data,
  output logic [INDEX_WIDTH-1:0] fill_index,
  output logic [TAG_WIDTH-1:0]   fill_tag,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [BEAT_WIDTH-1:0]  mem_rdata,
  output logic                   busy
);
  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int CW  = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DELIVER} state_t;
  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          owner_dc, mask_ic, mask_dc, ic_ok, dc_ok, pick_dc;
  logic [31:0]   win_addr;
  // the requester just served sits out the first IDLE cycle so the other side gets a turn
  assign ic_ok = ic_req && !mask_ic;
  assign dc_ok = dc_req && !mask_dc;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc;
  assign pick_dc = dc_ok && (!ic_ok || !last_dc);
`else
  assign pick_dc = dc_ok;
`endif
  assign win_addr = pick_dc ? dc_addr : ic_addr;
  assign busy     = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      owner_dc      <= 1'b0;
      mask_ic       <= 1'b0;
      mask_dc       <= 1'b0;
      ic_grant      <= 1'b0;
      dc_grant      <= 1'b0;
      ic_fill_valid <= 1'b0;
      dc_fill_valid <= 1'b0;
      fill_data     <= '0;
      fill_index    <= '0;
      fill_tag      <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dc       <= 1'b0;
`endif
    end else begin
      ic_grant      <= 1'b0;
      dc_grant      <= 1'b0;
      ic_fill_valid <= 1'b0;
      dc_fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          mask_ic <= 1'b0;
          mask_dc <= 1'b0;
          if (ic_ok || dc_ok) begin
            state      <= ISSUE;
            owner_dc   <= pick_dc;
            dc_grant   <= pick_dc;
            ic_grant   <= !pick_dc;
            mem_req    <= 1'b1;
            mem_addr   <= win_addr & ~32'(LINE_WIDTH / 8 - 1);
            fill_index <= win_addr[OFF +: INDEX_WIDTH];
            fill_tag   <= win_addr[OFF + INDEX_WIDTH +: TAG_WIDTH];
`ifdef ARB_ROUND_ROBIN_EN
            last_dc    <= pick_dc;
`endif
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= BURST;
          end
        end
        BURST: begin
          if (mem_rvalid) begin
            fill_data[beat_cnt * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
            beat_cnt <= (beat_cnt == CW'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
            if (beat_cnt == CW'(BEATS - 1)) begin
              state         <= DELIVER;
              dc_fill_valid <= owner_dc;
              ic_fill_valid <= !owner_dc;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mask_dc <= owner_dc;
          mask_ic <= !owner_dc;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb_cache_refill_arbiter: vector table, directed corner sequences and randomized traffic against a rule-level model
module tb_cache_refill_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ic_req = 1'b0, dc_req = 1'b0;
  logic [31:0]  ic_addr = '0, dc_addr = '0;
  logic         ic_grant, dc_grant, ic_fill_valid, dc_fill_valid;
  logic [511:0] fill_data;
  logic [7:0]   fill_index;
  logic [17:0]  fill_tag;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         busy;

  cache_refill_arbiter dut (
    .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr), .dc_req(dc_req), .dc_addr(dc_addr),
    .ic_grant(ic_grant), .dc_grant(dc_grant), .ic_fill_valid(ic_fill_valid), .dc_fill_valid(dc_fill_valid),
    .fill_data(fill_data), .fill_index(fill_index), .fill_tag(fill_tag), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // memory responder: ack after ack_delay extra cycles, then 16 beats with a chosen gap pattern
  int           ack_delay = 0, gap_mode = 0;
  bit           data_mode = 1'b0, stray_en = 1'b0;
  int           beats_left = 0, req_cyc = 0, burst_cyc = 0;
  logic [511:0] exp_line = '0;
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      if (reset) begin
        beats_left = 0;
        req_cyc = 0;
      end else begin
        if (beats_left > 0) begin
          if (gap_mode == 0 || (gap_mode == 1 && burst_cyc[0]) || (gap_mode == 2 && $urandom_range(0, 2) != 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata = data_mode ? $urandom : 32'(16 - beats_left);
            exp_line[32 * (16 - beats_left) +: 32] = mem_rdata;
            beats_left--;
          end
          burst_cyc++;
        end else if (stray_en && !mem_req) begin
          mem_ack = 1'($urandom_range(0, 1));
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
        if (mem_req) begin
          if (req_cyc >= ack_delay) begin
            mem_ack = 1'b1;
            beats_left = 16;
            burst_cyc = 0;
            exp_line = '0;
          end
          req_cyc++;
        end else req_cyc = 0;
      end
    end
  end

  // reference model: who must win at each IDLE edge, and what the fill must carry
  bit          s_rst = 1'b1, s_busy = 1'b0, s_ic = 1'b0, s_dc = 1'b0, s_mic = 1'b0, s_mdc = 1'b0;
  bit          icf_d = 1'b0, dcf_d = 1'b0;
  logic [31:0] s_ica = '0, s_dca = '0, o_addr = '0;
  bit          outst = 1'b0, o_dc = 1'b0, last_dc = 1'b0;
  always @(posedge clk) begin
    s_rst = reset; s_busy = busy; s_ic = ic_req; s_dc = dc_req; s_ica = ic_addr; s_dca = dc_addr;
    s_mic = icf_d; s_mdc = dcf_d; icf_d = ic_fill_valid; dcf_d = dc_fill_valid;
  end
  always @(negedge clk) begin
    bit e_ic, e_dc, w_dc, want;
    if (s_rst) begin
      outst = 1'b0;
      last_dc = 1'b0;
    end else begin
      e_ic = s_ic && !s_mic;
      e_dc = s_dc && !s_mdc;
`ifdef ARB_ROUND_ROBIN_EN
      w_dc = e_dc && (!e_ic || !last_dc);
`else
      w_dc = e_dc;
`endif
      want = !s_busy && (e_ic || e_dc);
      chk("grant", {ic_grant, dc_grant}, want ? {!w_dc, w_dc} : 2'b00);
      if (want) begin
        outst = 1'b1; o_dc = w_dc; o_addr = w_dc ? s_dca : s_ica; last_dc = w_dc;
      end
      if (mem_req) chk("mem_addr", mem_addr, o_addr & 32'hFFFF_FFC0);
      if (ic_fill_valid || dc_fill_valid) begin
        chk("fill_owner", {outst, ic_fill_valid, dc_fill_valid}, {1'b1, !o_dc, o_dc});
        chk("fill_index", fill_index, (o_addr >> 6) & 32'hFF);
        chk("fill_tag", fill_tag, o_addr >> 14);
        chk("fill_data", fill_data, exp_line);
        outst = 1'b0;
      end
    end
  end

  typedef struct {
    logic        ic, dc;
    logic [31:0] addr;
    int          delay, gap;
    logic        exp_dc;
    int          exp_fill;
    logic [7:0]  exp_idx;
    logic [17:0] exp_tag;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t         vecs[5];
  logic [511:0] seq_line;

  task automatic run_vec(input vec_t v);
    int g = 0, f = 0, mr = 0;
    bit gd = 1'b0, fd = 1'b0, stable = 1'b1;
    logic [7:0] idx = '0;
    logic [17:0] tag = '0;
    logic [511:0] data = '0;
    @(negedge clk);
    ack_delay = v.delay; gap_mode = v.gap; data_mode = 1'b0;
    ic_addr = v.addr; dc_addr = v.addr; ic_req = v.ic; dc_req = v.dc;
    for (int c = 1; c <= 200 && f == 0; c++) begin
      @(negedge clk);
      if ((ic_grant || dc_grant) && g == 0) begin g = c; gd = dc_grant; end
      if (mem_req) begin mr++; if (mem_addr !== v.exp_maddr) stable = 1'b0; end
      if (ic_fill_valid || dc_fill_valid) begin
        f = c; fd = dc_fill_valid; idx = fill_index; tag = fill_tag; data = fill_data;
        ic_req = 1'b0; dc_req = 1'b0;
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    chk("vec_grant_cycle", 32'(g), 32'd1);
    chk("vec_grant_owner", gd, v.exp_dc);
    chk("vec_fill_cycle", 32'(f), 32'(v.exp_fill));
    chk("vec_fill_owner", fd, v.exp_dc);
    chk("vec_mem_req_cycles", 32'(mr), 32'(v.delay + 1));
    chk("vec_mem_addr_stable", stable, 1'b1);
    chk("vec_index", idx, v.exp_idx);
    chk("vec_tag", tag, v.exp_tag);
    chk("vec_data", data, seq_line);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ng, nf, n;
    bit go[3];
    int gc[3];
    logic [511:0] fd0;
    for (int k = 0; k < 16; k++) seq_line[32 * k +: 32] = 32'(k);
    vecs[0] = '{1'b0, 1'b1, 32'h0001_2340, 0, 0, 1'b1, 18, 8'h8D, 18'h00004, 32'h0001_2340};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 0, 0, 1'b0, 18, 8'hFF, 18'h3FFFF, 32'hFFFF_FFC0};
    vecs[2] = '{1'b0, 1'b1, 32'h8000_0007, 5, 1, 1'b1, 39, 8'h00, 18'h20000, 32'h8000_0000};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_3FC0, 2, 0, 1'b0, 20, 8'hFF, 18'h00000, 32'h0000_3FC0};
    vecs[4] = '{1'b0, 1'b1, 32'h1234_5678, 1, 1, 1'b1, 35, 8'h59, 18'h048D1, 32'h1234_5640};
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {ic_grant, dc_grant, ic_fill_valid, dc_fill_valid, mem_req, busy, fill_index, fill_tag, mem_addr}, '0);
    chk("reset_data", fill_data, '0);
    reset = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);

    // both requesters held through three services
    @(negedge clk);
    ack_delay = 0; gap_mode = 0; data_mode = 1'b1;
    ic_addr = 32'hA5A5_0040; dc_addr = 32'h0BAD_F00C; ic_req = 1'b1; dc_req = 1'b1;
    ng = 0; nf = 0;
    for (int c = 1; c <= 200 && nf < 3; c++) begin
      @(negedge clk);
      if ((ic_grant || dc_grant) && ng < 3) begin go[ng] = dc_grant; gc[ng] = c; ng++; end
      if (ic_fill_valid || dc_fill_valid) nf++;
    end
    ic_req = 1'b0; dc_req = 1'b0;
    chk("both_count", 32'(nf), 32'd3);
    chk("both_order", {go[0], go[1], go[2]}, 3'b101);
    chk("both_cycles", {gc[0], gc[1], gc[2]}, {32'd1, 32'd20, 32'd39});
    repeat (3) @(negedge clk);

    // reset in the middle of a DC burst
    ack_delay = 0; gap_mode = 0; data_mode = 1'b0;
    dc_addr = 32'h0000_7780; dc_req = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", {ic_grant, dc_grant, ic_fill_valid, dc_fill_valid, mem_req, busy, fill_index, fill_tag, mem_addr}, '0);
    chk("abort_data", fill_data, '0);
    dc_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (30) begin @(negedge clk); if (dc_fill_valid) n++; end
    chk("abort_no_fill", 32'(n), 32'd0);
    data_mode = 1'b1; ic_addr = 32'h0042_1000; ic_req = 1'b1;
    n = 0; nf = 0;
    for (int c = 1; c <= 60 && n == 0; c++) begin
      @(negedge clk);
      if (ic_fill_valid) begin n = c; chk("fresh_data", fill_data, exp_line); ic_req = 1'b0; end
    end
    chk("fresh_fill_cycle", 32'(n), 32'd18);
    repeat (2) @(negedge clk);

    // stray memory handshakes while idle, then a request dropped mid-burst
    fd0 = fill_data; stray_en = 1'b1;
    repeat (12) begin @(negedge clk); chk("stray_idle", {busy, mem_req, ic_grant, dc_grant}, 4'b0); end
    stray_en = 1'b0;
    @(negedge clk);
    chk("stray_data_kept", fill_data, fd0);
    ack_delay = 0; gap_mode = 0; ic_addr = 32'hC0DE_0100; ic_req = 1'b1;
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 8) ic_req = 1'b0;
      if (ic_fill_valid) n++;
    end
    chk("dropped_fill_once", 32'(n), 32'd1);

    // randomized traffic from both caches
    data_mode = 1'b1; stray_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (c % 60 == 0) begin ack_delay = $urandom_range(0, 3); gap_mode = $urandom_range(0, 2); end
      if (ic_fill_valid) begin ic_req = 1'($urandom_range(0, 1)); ic_addr = $urandom; end
      else if (!ic_req && $urandom_range(0, 7) == 0) begin ic_req = 1'b1; ic_addr = $urandom; end
      if (dc_fill_valid) begin dc_req = 1'($urandom_range(0, 1)); dc_addr = $urandom; end
      else if (!dc_req && $urandom_range(0, 7) == 0) begin dc_req = 1'b1; dc_addr = $urandom; end
    end
    for (int c = 0; c < 300 && (ic_req || dc_req); c++) begin
      @(negedge clk);
      if (ic_fill_valid) ic_req = 1'b0;
      if (dc_fill_valid) dc_req = 1'b0;
    end
    chk("drain", {ic_req, dc_req}, 2'b00);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Sequences line refills for the instruction and data caches over one shared memory read port.
- Accepts miss requests from both caches and arbitrates between them.
- Issues one line-aligned burst read per request, assembles the returned beats into a full line, and delivers it with the target line index and tag.
- Sits between the caches' miss/request outputs and the memory interface.

Parameters:
- LINE_WIDTH, 512, bits per cache line.
- BEAT_WIDTH, 32, bits per memory read beat.
- BEATS, 16, beats per line (LINE_WIDTH/BEAT_WIDTH).
- INDEX_WIDTH, 8, line index width (address bits [13:6]).
- TAG_WIDTH, 18, tag width (address bits [31:14]).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  instruction cache miss request; held until ic_fill_valid
- ic_addr  in  32  instruction miss byte address
- dc_req  in  1  data cache miss request; held until dc_fill_valid
- dc_addr  in  32  data miss byte address
- ic_grant  out  1  one-cycle pulse: IC request accepted
- dc_grant  out  1  one-cycle pulse: DC request accepted
- ic_fill_valid  out  1  one-cycle pulse: fill bus carries the IC line
- dc_fill_valid  out  1  one-cycle pulse: fill bus carries the DC line
- fill_data  out  LINE_WIDTH  assembled line
- fill_index  out  INDEX_WIDTH  latched addr[13:6]
- fill_tag  out  TAG_WIDTH  latched addr[31:14]
- mem_req  out  1  burst read request
- mem_addr  out  32  line-aligned address {addr[31:6],6'b0}
- mem_ack  in  1  memory accepted mem_req
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  BEAT_WIDTH  read beat data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; beat_cnt 0; all outputs 0, including fill_data, fill_index, fill_tag and mem_addr. Reset mid-operation aborts immediately, discards partial data and drops mem_req on the same edge. No fill is delivered for an aborted request.
- States: IDLE, ISSUE, BURST, DELIVER.
- IDLE:
  - Sample ic_req/dc_req each edge.
  - If either is high: latch the winner's address and owner, go to ISSUE, and pulse the winner's grant for exactly the first ISSUE cycle.
  - Default arbitration is fixed priority, DC over IC.
  - The requester served by the immediately preceding DELIVER is masked for the first IDLE cycle only.
- ISSUE:
  - mem_req=1 and mem_addr valid, held stable until mem_ack is sampled high.
  - On mem_ack, go to BURST. mem_req drops the cycle after the ack cycle.
- BURST:
  - Each edge with mem_rvalid=1 writes mem_rdata into fill_data[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH], beat 0 in the LSBs, and increments beat_cnt.
  - Gaps (mem_rvalid=0) stall with no write.
  - On the beat with beat_cnt==BEATS-1: beat_cnt wraps to 0 and state goes to DELIVER.
- DELIVER:
  - Owner's fill_valid=1 for one cycle, with fill_data, fill_index and fill_tag stable.
  - Next state is IDLE, unconditionally.
- Minimum latency with zero-wait memory (mem_ack in the first ISSUE cycle, rvalid every cycle):
  - req sampled at edge N → grant in cycle N+1;
  - fill_valid in cycle N+18.
- mem_rvalid outside BURST is ignored; mem_ack outside ISSUE is ignored.
- A requester dropping req while its transaction is in flight does not cancel it; the fill is still delivered.
- A request from the non-owner during ISSUE/BURST/DELIVER is held off and not granted until IDLE.
- Only one outstanding transaction at a time. grant and fill_valid are never asserted for both requesters in the same cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: IDLE arbitration is round-robin.
  - A last_served register is updated at each grant; reset value is IC, so DC wins the first tie.
  - On simultaneous requests, the requester not in last_served wins.
  - The one-cycle post-DELIVER mask still applies.
- Undefined: fixed DC-over-IC priority, and no last_served register exists.

Test Plan:
- DC miss alone, dc_addr=0x0001_2340, zero-wait memory, rdata=beat number → dc_grant in cycle 1; mem_addr=0x0001_2340; dc_fill_valid in cycle 18; fill_index=0x8D; fill_tag=0x00004; fill_data[32*k+:32]=k for k=0..15.
- ic_req and dc_req asserted together and held → default: DC served first, IC granted in the first IDLE cycle after the DC fill. With ARB_ROUND_ROBIN_EN and both held through three services: order DC, IC, DC.
- mem_ack delayed 5 cycles, rvalid low on every other cycle → mem_req/mem_addr held stable for 6 cycles; beat order preserved; fill_valid exactly once, after the 16th valid beat.
- reset asserted after beat 7 of a DC burst → next cycle all outputs 0 and busy=0; no dc_fill_valid. A new ic_req afterwards completes normally with a fresh fill_data.
- Stray mem_rvalid/mem_ack pulses while IDLE; ic_req dropped mid-burst → no state change while IDLE; ic_fill_valid still pulses once for the dropped request.
